ft232h_sample_framer: RTL

- Upstream feeder for the FT232H async FIFO driver.
- Accepts fixed-width samples on a valid/ready interface and buffers them in an internal FIFO.
- Serialises each group of samples into a framed byte stream: sync, sequence, length, little-endian payload, XOR checksum.
- The byte stream goes to the driver's fifo_data_in/fifo_data_valid_in; byte_ready_in comes from the driver-side not-full indication.

---
 rtl/ft232h_sample_framer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ft232h_sample_framer.sv
// ft232h_sample_framer
// Buffers fixed-width samples in a small FIFO and serialises each group of
// SAMPLES_PER_PACKET samples into a framed byte stream for the FT232H driver:
//   A5 | seq | len | payload (little-endian per sample) | xor(seq,len,payload)
// A frame is only started once a whole packet is buffered, so the payload
// never underruns and bytes go out back-to-back while the sink is ready.
module ft232h_sample_framer #(
    parameter int SAMPLE_WIDTH       = 16,
    parameter int SAMPLES_PER_PACKET = 4,
    parameter int FIFO_DEPTH         = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid_in,
    output logic                    sample_ready_out,
    output logic [7:0]              byte_out,
    output logic                    byte_valid_out,
    input  logic                    byte_ready_in,
    output logic [15:0]             frame_count_out
);

    localparam int BPS = SAMPLE_WIDTH / 8;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = AW + 1;
    localparam int BIW = (BPS > 1) ? $clog2(BPS) : 1;

    localparam logic [7:0]     SYNC_BYTE = 8'hA5;
    localparam logic [7:0]     LEN_BYTE  = 8'(SAMPLES_PER_PACKET);
    localparam logic [7:0]     LAST_SAMP = 8'(SAMPLES_PER_PACKET - 1);
    localparam logic [BIW-1:0] LAST_BYTE = BIW'(BPS - 1);
    localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]  SPP_C     = CW'(SAMPLES_PER_PACKET);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_SEQ, S_LEN, S_PAYLOAD, S_CSUM
    } state_t;

    // sample FIFO
    logic [SAMPLE_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic                    r_ready;

    // framer
    state_t                  r_state;
    logic [7:0]              r_byte;
    logic                    r_valid;
    logic [7:0]              r_seq;
    logic [7:0]              r_csum;
    logic [7:0]              r_samp_idx;
    logic [BIW-1:0]          r_byte_idx;
    logic [15:0]             r_frames;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_xfer;
    logic                    w_last_byte;
    logic [BIW-1:0]          w_nidx;
    logic [CW-1:0]           w_next_count;
    logic [BPS-1:0][7:0]     w_head_bytes;

    assign w_push       = sample_valid_in && r_ready;
    assign w_xfer       = r_valid && byte_ready_in;
    assign w_last_byte  = (r_byte_idx == LAST_BYTE);
    assign w_pop        = (r_state == S_PAYLOAD) && w_xfer && w_last_byte;
    assign w_nidx       = r_byte_idx + BIW'(1);
    assign w_head_bytes = r_mem[r_rd_ptr];

    // occupancy after this edge; push and pop together leave it unchanged
    always_comb begin
        w_next_count = r_count;
        if (w_push && !w_pop)
            w_next_count = r_count + CW'(1);
        else if (w_pop && !w_push)
            w_next_count = r_count - CW'(1);
    end

    // sample storage (no reset needed: pointers define what is valid)
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= sample_in;
    end

    // FIFO pointers, occupancy and registered ready (low during reset)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_next_count;
            r_ready <= (w_next_count != DEPTH_C);
        end
    end

    // frame FSM; checksum folds in each byte as it is loaded into r_byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_byte     <= 8'h00;
            r_valid    <= 1'b0;
            r_seq      <= 8'h00;
            r_csum     <= 8'h00;
            r_samp_idx <= 8'h00;
            r_byte_idx <= '0;
            r_frames   <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count >= SPP_C) begin
                        r_state <= S_SYNC;
                        r_byte  <= SYNC_BYTE;
                        r_valid <= 1'b1;
                        r_csum  <= 8'h00;
                    end
                end
                S_SYNC: begin
                    if (w_xfer) begin
                        r_state <= S_SEQ;
                        r_byte  <= r_seq;
                        r_csum  <= r_seq;
                    end
                end
                S_SEQ: begin
                    if (w_xfer) begin
                        r_state <= S_LEN;
                        r_byte  <= LEN_BYTE;
                        r_csum  <= r_csum ^ LEN_BYTE;
                    end
                end
                S_LEN: begin
                    if (w_xfer) begin
                        r_state    <= S_PAYLOAD;
                        r_byte     <= w_head_bytes[0];
                        r_csum     <= r_csum ^ w_head_bytes[0];
                        r_samp_idx <= 8'h00;
                        r_byte_idx <= '0;
                    end
                end
                S_PAYLOAD: begin
                    if (w_xfer) begin
                        if (!w_last_byte) begin
                            r_byte_idx <= w_nidx;
                            r_byte     <= w_head_bytes[w_nidx];
                            r_csum     <= r_csum ^ w_head_bytes[w_nidx];
                        end else if (r_samp_idx == LAST_SAMP) begin
                            r_state <= S_CSUM;
                            r_byte  <= r_csum;
                        end else begin
                            // head is popped this edge, so look one slot ahead
                            r_samp_idx <= r_samp_idx + 8'h01;
                            r_byte_idx <= '0;
                            r_byte     <= r_mem[r_rd_ptr + AW'(1)][7:0];
                            r_csum     <= r_csum ^ r_mem[r_rd_ptr + AW'(1)][7:0];
                        end
                    end
                end
                S_CSUM: begin
                    if (w_xfer) begin
                        r_state  <= S_IDLE;
                        r_valid  <= 1'b0;
                        r_seq    <= r_seq + 8'h01;
                        r_frames <= r_frames + 16'h0001;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sample_ready_out = r_ready;
    assign byte_out         = r_byte;
    assign byte_valid_out   = r_valid;
    assign frame_count_out  = r_frames;

endmodule
